inst_mem_loader: RTL and testbench
==================================

Name: inst_mem_loader

Overview:
- Hardware program loader for the RVSEED instruction memory.
- Receives a framed little-endian byte stream over a valid/ready handshake and assembles 32-bit words.
- Writes the words sequentially into inst_mem from word address 0 and holds the core in reset until the image checksum verifies.
- Sits between a host byte source (UART/debug bridge) and the inst_mem write port plus the core's rst_n.

Parameters:
ADDR_WIDTH, 8, inst_mem word-address width; capacity 2^ADDR_WIDTH words
DATA_WIDTH, 32, memory word width; equals CPU_WIDTH; fixed at 32 (4 bytes per word)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
load_start  input  1  one-cycle pulse; begins a new load frame
byte_vld  input  1  byte_data valid
byte_data  input  8  stream byte
byte_rdy  output  1  loader accepts byte; transfer occurs when byte_vld && byte_rdy
mem_we  output  1  inst_mem write enable, one-cycle pulse per word
mem_addr  output  ADDR_WIDTH  inst_mem word address
mem_wdata  output  DATA_WIDTH  inst_mem write data
cpu_rst_n  output  1  core reset, active-low; 0 holds core in reset
load_busy  output  1  frame in progress
load_done  output  1  last frame loaded and checksum matched
load_err  output  1  last frame rejected

Behaviour:
- Reset values (asynchronous, on rst=1):
  - state=IDLE; byte_rdy=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_rst_n=0, load_busy=0, load_done=0, load_err=0.
- Frame format, bytes in order:
  - CNT_LO, CNT_HI: 16-bit word count N.
  - 4*N data bytes, each word little-endian (first byte -> bits[7:0]).
  - CSUM: 8-bit sum mod 256 of every preceding frame byte, including the count bytes.
- States: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR.
- IDLE/DONE/ERR + load_start=1:
  - go to LEN0; clear load_done and load_err; set load_busy=1.
  - drive cpu_rst_n=0 from the next cycle; clear the running sum, byte counter and word counter.
- byte_rdy=1 only in LEN0, LEN1, DATA, CSUM. It is registered, first high the cycle after load_start.
- LEN0: on handshake, latch N[7:0] and go to LEN1.
- LEN1: on handshake, latch N[15:8], then:
  - N > 2^ADDR_WIDTH -> ERR.
  - N = 0 -> CSUM.
  - else -> DATA.
- DATA:
  - Shift bytes into a 32-bit assembly register with a 2-bit byte counter.
  - On the 4th byte's handshake, in the next cycle: mem_we=1, mem_wdata=assembled word, mem_addr=word counter. The word counter then increments.
  - After word N-1 is written, go to CSUM.
  - mem_addr wraps naturally only at N = 2^ADDR_WIDTH (last address 2^ADDR_WIDTH-1). No write beyond that.
- CSUM: on handshake, compare byte_data with the running sum.
  - Match -> DONE: load_done=1, load_busy=0, cpu_rst_n=1, all the same cycle.
  - Mismatch -> ERR.
- ERR: load_err=1, load_busy=0, cpu_rst_n stays 0, byte_rdy=0.
- Words already written before an error remain in memory; software must reload.
- load_start while state is LEN0..CSUM is ignored (no restart mid-frame).
- load_start in DONE re-enters LEN0 and immediately reasserts the core reset (cpu_rst_n=0).
- byte_vld=0 stalls any state indefinitely. No timeout.
- rst asserted mid-frame: abort to reset values immediately; the partial word is discarded and no write is issued.
- mem_we never asserts in any cycle other than the one following a 4th data byte.
- At most one memory write per 4 accepted bytes. Throughput is 1 byte/cycle sustained.

Test Plan:
- Load N=2, words 0x00000013, 0x00100093, then CSUM=0x02+0x00+0x13+0x93+0x10=0xB8 -> mem_we pulses at addr 0 then 1 with those words; load_done=1; cpu_rst_n rises in the cycle CSUM is accepted.
- Same frame with CSUM=0xB9 -> load_err=1, cpu_rst_n=0, load_done=0; both mem writes still occur.
- N=0 with CSUM=0x00 -> no mem_we; load_done=1.
- ADDR_WIDTH=8: N=256 with a random image and correct sum -> 256 writes, last at addr 0xFF. N=257 -> ERR right after CNT_HI, zero writes.
- Random byte_vld gaps (50% duty) on the N=2 frame -> same writes and result as the back-to-back case; no write issued on an idle cycle.
- Assert rst after 6 data bytes, then a fresh full frame -> first write only after the new frame's 4th data byte, at addr 0, with correct data; load_start pulsed mid-frame has no effect.

Source files
------------

// File: rtl/inst_mem_loader.sv
// Program loader for the RVSEED instruction memory: takes a framed little-endian
// byte stream, writes 32-bit words from address 0 and releases the core once the checksum matches.
module inst_mem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  byte_vld,
    input  logic [7:0]            byte_data,
    output logic                  byte_rdy,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_rst_n,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_err,
    output logic [2:0]            fsm_state
);

    // Handshake: a byte transfers on a rising clk edge where byte_vld && byte_rdy;
    // byte_vld may be held low for any number of cycles, byte_rdy never depends on byte_vld.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN0 = 3'd1,
        LEN1 = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

    state_t      state, state_next;
    logic [15:0] word_total;
    logic [15:0] word_cnt;
    logic [15:0] n_len;
    logic [7:0]  sum;
    logic [1:0]  byte_cnt;
    logic [23:0] asm_reg;
    logic        xfer;
    logic        start_ok;
    logic        word_last_byte;
    logic        active_next;

    assign xfer           = byte_vld && byte_rdy;
    assign start_ok       = load_start && (state == IDLE || state == DONE || state == ERR);
    assign n_len          = {byte_data, word_total[7:0]};
    assign word_last_byte = xfer && (state == DATA) && (byte_cnt == 2'd3);
    assign fsm_state      = state;

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERR: if (load_start) state_next = LEN0;
            LEN0:            if (xfer) state_next = LEN1;
            LEN1: begin
                if (xfer) begin
                    if ({1'b0, n_len} > MAX_WORDS) state_next = ERR;
                    else if (n_len == 16'd0)       state_next = CSUM;
                    else                           state_next = DATA;
                end
            end
            DATA: begin
                if (word_last_byte && (word_cnt == word_total - 16'd1)) state_next = CSUM;
            end
            CSUM: begin
                if (xfer) state_next = (byte_data == sum) ? DONE : ERR;
            end
            default:         state_next = IDLE;
        endcase
    end

    assign active_next = (state_next == LEN0) || (state_next == LEN1) ||
                         (state_next == DATA) || (state_next == CSUM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Status outputs are registered images of the next state, so they settle together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_rdy  <= 1'b0;
            load_busy <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            cpu_rst_n <= 1'b0;
        end else begin
            byte_rdy  <= active_next;
            load_busy <= active_next;
            load_done <= (state_next == DONE);
            load_err  <= (state_next == ERR);
            cpu_rst_n <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_total <= '0;
            word_cnt   <= '0;
            sum        <= '0;
            byte_cnt   <= '0;
            asm_reg    <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            mem_we <= 1'b0;
            if (start_ok) begin
                sum      <= '0;
                byte_cnt <= '0;
                word_cnt <= '0;
            end else if (xfer) begin
                case (state)
                    LEN0: begin
                        word_total[7:0] <= byte_data;
                        sum             <= sum + byte_data;
                    end
                    LEN1: begin
                        word_total[15:8] <= byte_data;
                        sum              <= sum + byte_data;
                    end
                    DATA: begin
                        sum      <= sum + byte_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        asm_reg  <= {byte_data, asm_reg[23:8]};
                        // Fourth byte completes the word; the first byte already sits in bits [7:0].
                        if (byte_cnt == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= word_cnt[ADDR_WIDTH-1:0];
                            mem_wdata <= DATA_WIDTH'({byte_data, asm_reg});
                            word_cnt  <= word_cnt + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: framed loads, checksum errors, size limits, stalls and aborts.
module tb_inst_mem_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic          byte_vld;
    logic [7:0]    byte_data;
    logic          byte_rdy;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_rst_n;
    logic          load_busy;
    logic          load_done;
    logic          load_err;
    logic [2:0]    fsm_state;

    int vectors = 0;
    int miscompares = 0;

    logic [39:0] exp_q[$];
    logic [39:0] wr_q[$];
    logic [7:0]  frame_q[$];
    logic [31:0] word_q[$];

    inst_mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .byte_vld(byte_vld),
        .byte_data(byte_data), .byte_rdy(byte_rdy), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst_n(cpu_rst_n),
        .load_busy(load_busy), .load_done(load_done), .load_err(load_err),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // Capture every write pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) wr_q.push_back({mem_addr, mem_wdata});
    end

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int gap;
        int waited;
        bit got;
        gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        repeat (gap) @(negedge clk);
        got = 1'b0;
        waited = 0;
        while (!got && waited < 40) begin
            @(negedge clk);
            byte_vld = 1'b1;
            byte_data = b;
            got = (byte_rdy === 1'b1);
            @(posedge clk);
            #1;
            waited++;
        end
        byte_vld = 1'b0;
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL byte_accept: byte %02h never accepted, byte_rdy got 0 want 1", b);
        end
    endtask

    task automatic send_range(input int first, input int last, input int gap_max);
        for (int i = first; i <= last; i++) send_byte(frame_q[i], gap_max);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
    endtask

    // Builds frame_q from word_q with count n and checksum offset adj; fills exp_q.
    task automatic build_frame(input int n, input logic [7:0] adj);
        logic [7:0] s;
        logic [7:0] b;
        logic [7:0] a;
        frame_q = {};
        exp_q = {};
        wr_q = {};
        b = n[7:0];
        frame_q.push_back(b);
        s = b;
        b = n[15:8];
        frame_q.push_back(b);
        s = s + b;
        foreach (word_q[i]) begin
            for (int k = 0; k < 4; k++) begin
                b = word_q[i][8*k +: 8];
                frame_q.push_back(b);
                s = s + b;
            end
            a = i[7:0];
            exp_q.push_back({a, word_q[i]});
        end
        frame_q.push_back(s + adj);
    endtask

    task automatic test_reset();
        rst = 1'b1; load_start = 1'b0; byte_vld = 1'b0; byte_data = 8'h00;
        repeat (3) @(negedge clk);
        vectors++; if (byte_rdy !== 1'b0) begin miscompares++; $display("FAIL rst_byte_rdy: got %b want 0", byte_rdy); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        vectors++; if (mem_addr !== 8'h00) begin miscompares++; $display("FAIL rst_mem_addr: got %h want 00", mem_addr); end
        vectors++; if (mem_wdata !== 32'h0) begin miscompares++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
        vectors++; if (cpu_rst_n !== 1'b0) begin miscompares++; $display("FAIL rst_cpu_rst_n: got %b want 0", cpu_rst_n); end
        vectors++; if ({load_busy, load_done, load_err} !== 3'b000) begin miscompares++; $display("FAIL rst_status: got %b want 000", {load_busy, load_done, load_err}); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (fsm_state !== 3'd0 || byte_rdy !== 1'b0) begin miscompares++; $display("FAIL rst_idle: state %0d rdy %b want 0 0", fsm_state, byte_rdy); end
    endtask

    task automatic test_basic();
        word_q = '{32'h00000013, 32'h00100093};
        build_frame(2, 8'h00);
        vectors++; if (frame_q[10] !== 8'hB8) begin miscompares++; $display("FAIL basic_csum_model: got %h want b8", frame_q[10]); end
        pulse_start();
        vectors++; if (byte_rdy !== 1'b1 || load_busy !== 1'b1) begin miscompares++; $display("FAIL basic_start: rdy %b busy %b want 1 1", byte_rdy, load_busy); end
        send_range(0, 9, 0);
        vectors++; if (cpu_rst_n !== 1'b0) begin miscompares++; $display("FAIL basic_pre_csum_rst: got %b want 0", cpu_rst_n); end
        send_range(10, 10, 0);
        vectors++; if (cpu_rst_n !== 1'b1) begin miscompares++; $display("FAIL basic_cpu_rst_n: got %b want 1", cpu_rst_n); end
        vectors++; if ({load_busy, load_done, load_err, byte_rdy} !== 4'b0100) begin miscompares++; $display("FAIL basic_status: got %b want 0100", {load_busy, load_done, load_err, byte_rdy}); end
        repeat (2) @(negedge clk);
        vectors++; if (wr_q.size() != exp_q.size()) begin miscompares++; $display("FAIL basic_wr_count: got %0d want %0d", wr_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            vectors++; if (wr_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL basic_wr[%0d]: got %h want %h", i, wr_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_bad_csum();
        word_q = '{32'h00000013, 32'h00100093};
        build_frame(2, 8'h01);
        pulse_start();
        @(negedge clk);
        vectors++; if (cpu_rst_n !== 1'b0 || load_done !== 1'b0) begin miscompares++; $display("FAIL bad_restart: rst_n %b done %b want 0 0", cpu_rst_n, load_done); end
        send_range(0, 10, 0);
        vectors++; if ({load_busy, load_done, load_err, cpu_rst_n, byte_rdy} !== 5'b00100) begin miscompares++; $display("FAIL bad_status: got %b want 00100", {load_busy, load_done, load_err, cpu_rst_n, byte_rdy}); end
        repeat (2) @(negedge clk);
        vectors++; if (wr_q.size() != exp_q.size()) begin miscompares++; $display("FAIL bad_wr_count: got %0d want %0d", wr_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            vectors++; if (wr_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL bad_wr[%0d]: got %h want %h", i, wr_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_zero();
        word_q = {};
        build_frame(0, 8'h00);
        pulse_start();
        vectors++; if (load_err !== 1'b0) begin miscompares++; $display("FAIL zero_err_clear: got %b want 0", load_err); end
        send_range(0, 2, 0);
        vectors++; if ({load_done, load_err, cpu_rst_n} !== 3'b101) begin miscompares++; $display("FAIL zero_status: got %b want 101", {load_done, load_err, cpu_rst_n}); end
        repeat (2) @(negedge clk);
        vectors++; if (wr_q.size() != 0) begin miscompares++; $display("FAIL zero_writes: got %0d want 0", wr_q.size()); end
    endtask

    task automatic test_full();
        word_q = {};
        for (int i = 0; i < 256; i++) word_q.push_back($urandom());
        build_frame(256, 8'h00);
        pulse_start();
        send_range(0, frame_q.size() - 1, 0);
        vectors++; if ({load_done, load_err, cpu_rst_n} !== 3'b101) begin miscompares++; $display("FAIL full_status: got %b want 101", {load_done, load_err, cpu_rst_n}); end
        repeat (2) @(negedge clk);
        vectors++; if (wr_q.size() != 256) begin miscompares++; $display("FAIL full_wr_count: got %0d want 256", wr_q.size()); end
        else begin
            vectors++; if (wr_q[255][39:32] !== 8'hFF) begin miscompares++; $display("FAIL full_last_addr: got %h want ff", wr_q[255][39:32]); end
            foreach (exp_q[i]) begin
                vectors++; if (wr_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL full_wr[%0d]: got %h want %h", i, wr_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_overflow();
        word_q = {};
        build_frame(257, 8'h00);
        pulse_start();
        send_range(0, 1, 0);
        vectors++; if ({load_busy, load_done, load_err, cpu_rst_n, byte_rdy} !== 5'b00100) begin miscompares++; $display("FAIL ovf_status: got %b want 00100", {load_busy, load_done, load_err, cpu_rst_n, byte_rdy}); end
        repeat (4) @(negedge clk);
        vectors++; if (wr_q.size() != 0) begin miscompares++; $display("FAIL ovf_writes: got %0d want 0", wr_q.size()); end
    endtask

    task automatic test_gaps();
        word_q = '{32'h00000013, 32'h00100093};
        build_frame(2, 8'h00);
        pulse_start();
        send_range(0, 10, 1);
        vectors++; if ({load_done, load_err, cpu_rst_n} !== 3'b101) begin miscompares++; $display("FAIL gaps_status: got %b want 101", {load_done, load_err, cpu_rst_n}); end
        repeat (2) @(negedge clk);
        vectors++; if (wr_q.size() != exp_q.size()) begin miscompares++; $display("FAIL gaps_wr_count: got %0d want %0d", wr_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            vectors++; if (wr_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL gaps_wr[%0d]: got %h want %h", i, wr_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_abort();
        word_q = '{32'h00000013, 32'h00100093};
        build_frame(2, 8'h00);
        pulse_start();
        send_range(0, 3, 0);
        pulse_start();
        vectors++; if (fsm_state !== 3'd3 || load_busy !== 1'b1) begin miscompares++; $display("FAIL abort_midstart: state %0d busy %b want 3 1", fsm_state, load_busy); end
        send_range(4, 7, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (wr_q.size() != 1) begin miscompares++; $display("FAIL abort_writes: got %0d want 1", wr_q.size()); end
        else begin
            vectors++; if (wr_q[0] !== {8'h00, 32'h00000013}) begin miscompares++; $display("FAIL abort_wr0: got %h want 0000000013", wr_q[0]); end
        end
        vectors++; if (fsm_state !== 3'd0 || mem_addr !== 8'h00) begin miscompares++; $display("FAIL abort_reset: state %0d addr %h want 0 00", fsm_state, mem_addr); end
        word_q = '{32'hDEADBEEF, 32'h12345678};
        build_frame(2, 8'h00);
        pulse_start();
        send_range(0, 4, 0);
        @(negedge clk);
        vectors++; if (wr_q.size() != 0) begin miscompares++; $display("FAIL abort_early_write: got %0d want 0", wr_q.size()); end
        send_range(5, 5, 0);
        @(negedge clk);
        #1;
        vectors++; if (wr_q.size() != 1 || wr_q[0] !== {8'h00, 32'hDEADBEEF}) begin miscompares++; $display("FAIL abort_first_write: count %0d want 1, word want 00deadbeef", wr_q.size()); end
        send_range(6, 10, 0);
        vectors++; if ({load_done, load_err, cpu_rst_n} !== 3'b101) begin miscompares++; $display("FAIL abort_reload_status: got %b want 101", {load_done, load_err, cpu_rst_n}); end
        repeat (2) @(negedge clk);
        vectors++; if (wr_q.size() != exp_q.size()) begin miscompares++; $display("FAIL abort_wr_count: got %0d want %0d", wr_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            vectors++; if (wr_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL abort_wr[%0d]: got %h want %h", i, wr_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_csum();
        test_zero();
        test_full();
        test_overflow();
        test_gaps();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
